// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch-stage PC generator.
//   RESET_PC_DEFAULT : boot vector used when no RESET_PC override is given
//   REDIR_IDX_W      : width of a redirect channel index (up to 32 channels)
//   redir_ch_e       : well-known redirect channel indices, 0 = highest priority
//   redir_t          : one redirect request {valid, idx, pc} at the reference PC width
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam int          REDIR_IDX_W      = 5;
  localparam int          REDIR_PC_W       = 32;

  typedef enum logic [REDIR_IDX_W-1:0] {
    REDIR_EXC     = 5'd0,
    REDIR_BR_MISS = 5'd1,
    REDIR_JUMP    = 5'd2,
    REDIR_BR_PRED = 5'd3
  } redir_ch_e;

  typedef struct packed {
    logic                   valid;
    logic [REDIR_IDX_W-1:0] idx;
    logic [REDIR_PC_W-1:0]  pc;
  } redir_t;

endpackage

// File: rtl/redir_prio_arb.sv
// redir_prio_arb: lowest-index-wins priority encoder over redirect channels.
//   req_vld : per-channel request
//   req_pc  : per-channel target, channel k at [k*ADDR_W +: ADDR_W]
//   win_vld : any channel requesting
//   win_idx : index of the winning (lowest) channel
//   win_pc  : target of the winning channel
module redir_prio_arb
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_REDIR = 4
) (
  input  logic [NUM_REDIR-1:0]        req_vld,
  input  logic [NUM_REDIR*ADDR_W-1:0] req_pc,
  output logic                        win_vld,
  output logic [REDIR_IDX_W-1:0]      win_idx,
  output logic [ADDR_W-1:0]           win_pc
);

  // Scan from the highest index down so the lowest requesting channel is
  // the last assignment and therefore the winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_pc  = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (req_vld[k]) begin
        win_vld = 1'b1;
        win_idx = REDIR_IDX_W'(k);
        win_pc  = req_pc[k*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-block PC generator with prioritised redirects.
// A redirect seen while stalled is held in a pending entry and applied on
// the first unstalled cycle; an older pending redirect beats a younger new one.
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : front-end stall, PC held while high
//   fetch_ready_i   : I-cache accepted the current request
//   redir_valid_i   : per-channel redirect request (index 0 = highest priority)
//   redir_pc_i      : per-channel redirect target
//   pc_o            : current fetch PC
//   pc_valid_o      : pc_o is a valid request
//   slot_mask_o     : valid instruction slots in the current block
//   redir_pending_o : a held redirect is waiting for the stall to release
//   flush_o         : PC is being loaded from a redirect this cycle
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                FETCH_W   = 2,
  parameter int                NUM_REDIR = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        fetch_ready_i,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc_i,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        pc_valid_o,
  output logic [FETCH_W-1:0]          slot_mask_o,
  output logic                        redir_pending_o,
  output logic                        flush_o
);

  localparam int                OFS      = $clog2(FETCH_W);
  localparam int                SLOT_W   = (OFS > 0) ? OFS : 1;
  localparam int                BLK_B    = FETCH_W * 4;
  localparam logic [ADDR_W-1:0] BLK_INC  = ADDR_W'(BLK_B);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'(BLK_B - 1));

  logic [ADDR_W-1:0]      pc_p0;
  logic                   pc_vld_p0;
  logic                   pend_vld_p0;
  logic [REDIR_IDX_W-1:0] pend_idx_p0;
  logic [ADDR_W-1:0]      pend_pc_p0;

  logic                   new_vld;
  logic [REDIR_IDX_W-1:0] new_idx;
  logic [ADDR_W-1:0]      new_pc;

  logic                   pend_wins;
  logic                   cand_vld;
  logic [REDIR_IDX_W-1:0] cand_idx;
  logic [ADDR_W-1:0]      cand_pc;
  logic [ADDR_W-1:0]      seq_pc;
  logic [SLOT_W-1:0]      slot_idx;

  redir_prio_arb #(
    .ADDR_W    (ADDR_W),
    .NUM_REDIR (NUM_REDIR)
  ) u_new_arb (
    .req_vld (redir_valid_i),
    .req_pc  (redir_pc_i),
    .win_vld (new_vld),
    .win_idx (new_idx),
    .win_pc  (new_pc)
  );

  // ---- stage p0 inputs: candidate selection and sequential PC ----
  // Pending wins only when strictly older; a tie means the same channel
  // fired again and the newer target is the one to follow.
  always_comb begin
    pend_wins = pend_vld_p0 && (!new_vld || (pend_idx_p0 < new_idx));
    cand_vld  = pend_vld_p0 || new_vld;
    cand_idx  = pend_wins ? pend_idx_p0 : new_idx;
    cand_pc   = pend_wins ? pend_pc_p0  : new_pc;
    seq_pc    = (pc_p0 & BLK_MASK) + BLK_INC;
  end

  assign flush_o = !rst && !stall_i && cand_vld;

  // ---- stage p0 registers: PC, valid and pending control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0       <= RESET_PC;
      pc_vld_p0   <= 1'b0;
      pend_vld_p0 <= 1'b0;
    end else begin
      pc_vld_p0 <= 1'b1;
      if (cand_vld) begin
        if (stall_i) begin
          pend_vld_p0 <= 1'b1;
        end else begin
          pc_p0       <= cand_pc;
          pend_vld_p0 <= 1'b0;
        end
      end else if (!stall_i && pc_vld_p0 && fetch_ready_i) begin
        pc_p0 <= seq_pc;
      end
    end
  end

  // Pending payload is only meaningful while pend_vld_p0 is set.
  always_ff @(posedge clk) begin
    if (stall_i && cand_vld) begin
      pend_idx_p0 <= cand_idx;
      pend_pc_p0  <= cand_pc;
    end
  end

  // ---- stage p0 outputs ----
  generate
    if (FETCH_W == 1) begin : g_one_slot
      assign slot_idx = 1'b0;
    end else begin : g_multi_slot
      assign slot_idx = pc_p0[OFS+1:2];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      slot_mask_o[i] = pc_vld_p0 && (32'(i) >= 32'(slot_idx));
    end
  end

  assign pc_o            = pc_p0;
  assign pc_valid_o      = pc_vld_p0;
  assign redir_pending_o = pend_vld_p0;

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  localparam int AW = 32;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall_i = 1'b0;
  logic              fetch_ready_i = 1'b0;
  logic [NR-1:0]     redir_valid_i = '0;
  logic [NR*AW-1:0]  redir_pc_i = '0;

  logic [AW-1:0] pc2, pc4;
  logic          pv2, pv4, pend2, pend4, flush2, flush4;
  logic [1:0]    mask2;
  logic [3:0]    mask4;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = FETCH_W 2, index 1 = FETCH_W 4
  logic [31:0] m_pc [2];
  bit          m_pv [2];
  redir_t      m_pend [2];

  always #5 clk = ~clk;

  fetch_pc_gen #(.ADDR_W(AW), .FETCH_W(2), .NUM_REDIR(NR)) dut2 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
    .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
    .pc_o(pc2), .pc_valid_o(pv2), .slot_mask_o(mask2),
    .redir_pending_o(pend2), .flush_o(flush2)
  );

  fetch_pc_gen #(.ADDR_W(AW), .FETCH_W(4), .NUM_REDIR(NR)) dut4 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
    .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
    .pc_o(pc4), .pc_valid_o(pv4), .slot_mask_o(mask4),
    .redir_pending_o(pend4), .flush_o(flush4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(int fw, logic [31:0] pc, bit pv);
    logic [3:0] m = '0;
    int slot = int'((pc >> 2) % fw);
    for (int i = 0; i < fw; i++) if (pv && i >= slot) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_seq(int fw, logic [31:0] pc);
    longint unsigned p = pc;
    longint unsigned blk = longint'(fw * 4);
    return 32'((p / blk + 1) * blk);
  endfunction

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  // One clock: drive inputs, check both DUTs against the model, advance model.
  task automatic step(input bit r, input bit s, input bit rd, input logic [3:0] v,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] p2, input logic [31:0] p3, input bit ce);
    logic [31:0] pcs [4];
    @(negedge clk);
    rst = r; stall_i = s; fetch_ready_i = rd;
    redir_valid_i = v; redir_pc_i = {p3, p2, p1, p0};
    pcs[0] = p0; pcs[1] = p1; pcs[2] = p2; pcs[3] = p3;
    #1;
    for (int j = 0; j < 2; j++) begin
      int fw = (j == 0) ? 2 : 4;
      int nk = -1;
      redir_t c = '0;
      logic [31:0] opc = (j == 0) ? pc2 : pc4;
      logic        opv = (j == 0) ? pv2 : pv4;
      logic [3:0]  om  = (j == 0) ? {2'b00, mask2} : mask4;
      logic        opd = (j == 0) ? pend2 : pend4;
      logic        ofl = (j == 0) ? flush2 : flush4;
      for (int k = NR - 1; k >= 0; k--) if (v[k]) nk = k;
      if (m_pend[j].valid && (nk < 0 || int'(m_pend[j].idx) < nk)) c = m_pend[j];
      else if (nk >= 0) begin
        c.valid = 1'b1; c.idx = REDIR_IDX_W'(nk); c.pc = pcs[nk];
      end
      if (ce) begin
        chk($sformatf("fw%0d_pc", fw), opc, m_pc[j]);
        chk($sformatf("fw%0d_pc_valid", fw), 32'(opv), 32'(m_pv[j]));
        chk($sformatf("fw%0d_slot_mask", fw), 32'(om), 32'(exp_mask(fw, m_pc[j], m_pv[j])));
        chk($sformatf("fw%0d_pending", fw), 32'(opd), 32'(m_pend[j].valid));
        chk($sformatf("fw%0d_flush", fw), 32'(ofl), 32'(!r && !s && c.valid));
      end
      if (r) begin
        m_pc[j] = RESET_PC_DEFAULT; m_pv[j] = 1'b0; m_pend[j] = '0;
      end else begin
        if (s && c.valid) m_pend[j] = c;
        else if (!s && c.valid) begin
          m_pc[j] = c.pc; m_pend[j] = '0;
        end else if (!s && m_pv[j] && rd) m_pc[j] = exp_seq(fw, m_pc[j]);
        m_pv[j] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [3:0] rv;
    for (int j = 0; j < 2; j++) begin
      m_pc[j] = RESET_PC_DEFAULT; m_pv[j] = 1'b0; m_pend[j] = '0;
    end

    // Test 1: reset then ready held high
    step(1, 0, 1, 4'h0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t1_first_pc", pc2, 32'hbfc0_0000);
    chk("t1_first_valid", 32'(pv2), 32'd1);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t1_pc_seq1", pc2, 32'hbfc0_0008);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t1_pc_seq2", pc2, 32'hbfc0_0010);
    chk("t1_mask", 32'(mask2), 32'b11);

    // Test 2: unstalled redirect on the jump channel
    rv = '0; rv[REDIR_JUMP] = 1'b1;
    step(0, 0, 1, rv, 0, 0, 32'h8000_0004, 0, 1);
    peek();
    chk("t2_pc", pc2, 32'h8000_0004);
    chk("t2_mask", 32'(mask2), 32'b10);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t2_pc_seq", pc2, 32'h8000_0008);

    // Test 3: redirects held under stall, older channel wins
    step(0, 1, 1, 4'b1000, 0, 0, 0, 32'h8000_1000, 1);
    step(0, 1, 1, 4'b0010, 0, 32'h8000_2000, 0, 0, 1);
    step(0, 1, 1, 4'b1000, 0, 0, 0, 32'h8000_1000, 1);
    peek();
    chk("t3_pending", 32'(pend2), 32'd1);
    chk("t3_pc_held", pc2, 32'h8000_0008);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t3_pc_release", pc2, 32'h8000_2000);
    chk("t3_pending_clr", 32'(pend2), 32'd0);

    // Test 4: younger redirect dropped behind pending exception
    step(0, 1, 1, 4'b0001, 32'hbfc0_0380, 0, 0, 0, 1);
    step(0, 1, 1, 4'b1000, 0, 0, 0, 32'h1234_0000, 1);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t4_pc", pc2, 32'hbfc0_0380);

    // Test 5: simultaneous requests, not ready; then address wrap
    step(0, 0, 0, 4'b0011, 32'ha000_0000, 32'hb000_0000, 0, 0, 1);
    peek();
    chk("t5_pc", pc2, 32'ha000_0000);
    step(0, 0, 1, 4'b0001, 32'hffff_fff8, 0, 0, 0, 1);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t5_wrap_fw2", pc2, 32'h0000_0000);
    chk("t5_wrap_fw4", pc4, 32'h0000_0000);

    // Test 6: FETCH_W 4 slot mask, and reset discarding a pending redirect
    step(0, 0, 1, 4'b0001, 32'h0000_0008, 0, 0, 0, 1);
    peek();
    chk("t6_pc4", pc4, 32'h0000_0008);
    chk("t6_mask4", 32'(mask4), 32'b1100);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 1);
    peek();
    chk("t6_pc4_seq", pc4, 32'h0000_0010);
    step(0, 1, 1, 4'b0100, 0, 0, 32'h5555_0000, 0, 1);
    peek();
    chk("t6_pending4", 32'(pend4), 32'd1);
    step(1, 1, 1, 4'b0100, 0, 0, 32'h5555_0000, 0, 1);
    peek();
    chk("t6_rst_pc4", pc4, 32'hbfc0_0000);
    chk("t6_rst_pending4", 32'(pend4), 32'd0);
    chk("t6_rst_valid4", 32'(pv4), 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] v = '0;
      for (int k = 0; k < NR; k++) v[k] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, v,
           $urandom, $urandom, $urandom, $urandom, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
